// File: rtl/sos_sample_ingress.sv
// rtl/sos_sample_ingress.sv - widens and channel-tags input samples ahead of the SOS cascade
// A main output register plus one skid register keep 1 sample/clock with a registered in_ready_o.
module sos_sample_ingress #(
  parameter int S_WD    = 16,
  parameter int L_WD    = 32,
  parameter int FRAC_SH = 0,
  parameter int N_CH    = 1,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [S_WD-1:0]   in_data_i,
  input  logic              frame_start_i,
  input  logic [1:0]        mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [L_WD-1:0]   out_data_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic              out_last_o,
  output logic              frame_err_o
);

  localparam int PW = L_WD + CH_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] beat_ch;
  logic [CH_W-1:0] ch_next;
  logic [1:0]      mode_q;
  logic [1:0]      eff_mode;
  logic [S_WD-1:0] adj;
  logic [L_WD-1:0] ext;
  logic [L_WD-1:0] fmt;
  logic [PW-1:0]   beat;
  logic [PW-1:0]   skid_q;
  logic            skid_valid_q;
  logic            accept;
  logic            main_load;

  assign accept    = in_valid_i & in_ready_o;
  assign main_load = !out_valid_o || out_ready_i;

  // Channel 0 takes its mode straight from mode_i; later channels reuse the latched frame mode.
  always_comb begin
    beat_ch  = frame_start_i ? '0 : ch_q;
    ch_next  = (beat_ch == LAST_CH) ? '0 : beat_ch + CH_W'(1);
    eff_mode = (beat_ch == '0) ? mode_i : mode_q;
    adj      = in_data_i;
    if (eff_mode == 2'b10) adj[S_WD-1] = ~in_data_i[S_WD-1];
    ext            = {L_WD{(eff_mode != 2'b00) & adj[S_WD-1]}};
    ext[S_WD-1:0]  = adj;
    fmt            = ext << FRAC_SH;
    beat           = {beat_ch == LAST_CH, beat_ch, fmt};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q         <= '0;
      mode_q       <= 2'b01;
      frame_err_o  <= 1'b0;
      in_ready_o   <= 1'b1;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_ch_o     <= '0;
      out_last_o   <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        ch_q <= ch_next;
        if (beat_ch == '0) mode_q <= mode_i;
        if (frame_start_i && ch_q != '0) frame_err_o <= 1'b1;
      end
      // in_ready_o tracks the next value of skid_valid_q so it never depends on out_ready_i combinationally.
      if (main_load) begin
        if (skid_valid_q) begin
          {out_last_o, out_ch_o, out_data_o} <= skid_q;
          out_valid_o  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          {out_last_o, out_ch_o, out_data_o} <= beat;
          out_valid_o <= 1'b1;
        end else begin
          out_valid_o <= 1'b0;
        end
        in_ready_o <= 1'b1;
      end else begin
        if (accept) begin
          skid_q       <= beat;
          skid_valid_q <= 1'b1;
        end
        in_ready_o <= !(skid_valid_q || accept);
      end
    end
  end

endmodule

// File: tb/tb_sos_sample_ingress.sv
// tb/tb_sos_sample_ingress.sv - queue-model scoreboard plus directed literal checks for sos_sample_ingress
module tb_sos_sample_ingress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        frame_start = 1'b0;
  logic [1:0]  mode = 2'b01;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  bit soak = 0;

  sos_sample_ingress #(.S_WD(16), .L_WD(32), .FRAC_SH(4), .N_CH(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .frame_start_i(frame_start), .mode_i(mode),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_last_o(out_last), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  ch;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   m_ch;
  logic [1:0] m_mode;
  bit   m_err;
  bit   m_acc, m_xfer;
  int   m_c;
  exp_t m_e;

  function automatic logic [31:0] model_fmt(logic [15:0] d, logic [1:0] m);
    longint v;
    case (m)
      2'b00:   v = longint'(d);
      2'b10:   v = longint'(d) - 32768;
      default: v = longint'($signed(d));
    endcase
    return 32'(v * 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the block holds at most two samples in order; ready whenever fewer than two are held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ch = 0;
      m_mode = 2'b01;
      m_err = 0;
    end else begin
      m_acc  = in_valid && (q.size() < 2);
      m_xfer = (q.size() > 0) && out_ready;
      if (m_xfer) void'(q.pop_front());
      if (m_acc) begin
        m_c = frame_start ? 0 : m_ch;
        if (frame_start && m_ch != 0) m_err = 1;
        if (m_c == 0) m_mode = mode;
        m_e.d = model_fmt(in_data, m_mode);
        m_e.ch = 2'(m_c);
        m_e.last = (m_c == 2);
        q.push_back(m_e);
        m_ch = (m_c + 1) % 3;
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_ch", 32'(out_ch), 32'(q[0].ch));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end
  end

  task automatic send(input logic [15:0] d, input logic fs, input logic [1:0] m);
    int target;
    in_valid = 1'b1;
    in_data = d;
    frame_start = fs;
    mode = m;
    target = acc_cnt + 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (soak) out_ready = 1'($urandom_range(0, 1));
      if (acc_cnt >= target) break;
    end
    if (acc_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: accepted %0d expected %0d", acc_cnt, target);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame3(input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp);
    send(d, 1'b1, m);
    #1 chk("fmt_ch0", out_data, exp);
    #1 send(d, 1'b0, m ^ 2'b01);
    #1 chk("fmt_ch1", out_data, exp);
    #1 send(d, 1'b0, m ^ 2'b11);
    #1 chk("fmt_ch2", out_data, exp);
    chk("fmt_last", 32'(out_last), 32'd1);
    #1;
  endtask

  logic [1:0]  tag_ch[7]   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic        tag_last[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #12 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #2;

    frame3(16'h8001, 2'b01, 32'hFFF80010);
    frame3(16'h8001, 2'b00, 32'h00080010);
    frame3(16'h8001, 2'b10, 32'h00000010);
    frame3(16'h8001, 2'b11, 32'hFFF80010);
    frame3(16'h0000, 2'b10, 32'hFFF80000);
    frame3(16'hFFFF, 2'b10, 32'h0007FFF0);

    // Seven back-to-back beats, one frame_start, mode_i changes on beat 4
    for (int i = 0; i < 7; i++) begin
      send(16'h8001, i == 0, (i < 4) ? 2'b00 : 2'b01);
      #1;
      chk("tag_ch", 32'(out_ch), 32'(tag_ch[i]));
      chk("tag_last", 32'(out_last), 32'(tag_last[i]));
      chk("tag_data", out_data, (i < 6) ? 32'h00080010 : 32'hFFF80010);
      #1;
    end

    // Counter now sits at channel 1: frame_start here is a framing error
    chk("err_before", 32'(frame_err), 32'd0);
    send(16'h1234, 1'b1, 2'b01);
    #1;
    chk("err_set", 32'(frame_err), 32'd1);
    chk("err_beat_ch", 32'(out_ch), 32'd0);
    #1 send(16'h0001, 1'b0, 2'b01);
    #1 send(16'h0002, 1'b0, 2'b01);
    idle();
    repeat (3) @(posedge clk);
    #2 chk("err_sticky", 32'(frame_err), 32'd1);

    // Backpressure: two samples buffered, then in_ready drops
    out_ready = 1'b0;
    send(16'h0001, 1'b1, 2'b01);
    #1 chk("bp_ready_1", 32'(in_ready), 32'd1);
    #1 send(16'h0002, 1'b0, 2'b01);
    #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_hold_data", out_data, 32'h00000010);
    #1;
    in_data = 16'h0003;
    frame_start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("bp_still_full", 32'(in_ready), 32'd0);
      chk("bp_stable", out_data, 32'h00000010);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drain_second", out_data, 32'h00000020);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    #1 send(16'h0003, 1'b0, 2'b01);
    idle();
    repeat (3) @(posedge clk);
    #2;

    // Async reset with both registers full
    out_ready = 1'b0;
    send(16'h0011, 1'b1, 2'b01);
    send(16'h0022, 1'b0, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_frame_err", 32'(frame_err), 32'd0);
    idle();
    #4 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2 send(16'h0033, 1'b0, 2'b01);
    #1;
    chk("post_rst_ch", 32'(out_ch), 32'd0);
    chk("post_rst_data", out_data, 32'h00000330);
    #1;

    // Random-ready soak
    soak = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle();
        @(posedge clk);
        #2 out_ready = 1'($urandom_range(0, 1));
      end
      send(16'($urandom), (i % 3) == 1, 2'($urandom));
    end
    soak = 0;
    idle();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("soak_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/sos_sample_ingress.md
# sos_sample_ingress

Input-side sample formatter for the cascade SOS IIR datapath. It accepts narrow ADC/host samples over a valid/ready handshake and widens each to the internal accumulator width. Widening is zero-extend, sign-extend or offset-binary conversion, followed by a fixed Q-format left shift. Each sample is tagged with its channel index for time-multiplexed multi-channel operation, and a two-entry skid buffer sustains one sample per clock into the first SOS section.

## Interface
- S_WD, 16, input sample width (>=2)
- L_WD, 32, output sample width; legal only if L_WD >= S_WD+FRAC_SH
- FRAC_SH, 0, left shift applied after extension (fractional alignment), 0..L_WD-S_WD
- N_CH, 1, channels per frame (>=1); CH_W = max(1, $clog2(N_CH))
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  block can accept a sample
- in_data_i  in  S_WD  raw sample
- frame_start_i  in  1  qualifies the current input beat as channel 0 of a new frame
- mode_i  in  2  00 zero-extend, 01 sign-extend, 10 offset-binary to two's complement, 11 treated as 01
- out_valid_o  out  1  formatted sample valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  L_WD  formatted sample
- out_ch_o  out  CH_W  channel index of out_data_o
- out_last_o  out  1  out_ch_o == N_CH-1
- frame_err_o  out  1  sticky: frame_start_i seen with channel counter != 0

## Operation
- Accept when in_valid_i && in_ready_o.
- Channel counter ch_q: on accept, if frame_start_i then the beat is channel 0 and ch_q becomes 1 (or 0 if N_CH==1). Otherwise the beat uses ch_q, and ch_q increments, wrapping N_CH-1 -> 0.
- Mode latch: mode_q is loaded from mode_i on every accept whose channel is 0. All beats of a frame use mode_q; the ch-0 beat uses mode_i directly. A mode_i change mid-frame is ignored.
- Format, as a combinational function of the channel's effective mode:
  - 00: upper L_WD-S_WD bits are 0.
  - 01: upper bits are copies of in_data_i[S_WD-1].
  - 10: MSB is inverted first, then sign-extended.
  - The result is then shifted left by FRAC_SH with zero fill. No bits are lost; there is no saturation.
- frame_err_o: set on an accept with frame_start_i=1 while ch_q != 0. The beat is still processed as channel 0 and the counter is resynchronised. Only reset clears it.
- Buffering uses a main output register plus one skid register.
  - in_ready_o = !skid_valid_q. It is a registered signal with no combinational path from out_ready_i.
  - Output stalled (out_valid_o && !out_ready_i) and a beat accepted: the beat goes to the skid register.
  - When the main register drains, it reloads from skid if skid is valid, else from the new accept.
  - Order is strictly preserved, and data/ch/last travel together.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_ch_o=0, out_last_o=0, frame_err_o=0, ch_q=0, mode_q=01. Skid is empty.
- Reset mid-operation: buffered samples are discarded immediately (async). The first cycle after release behaves as a fresh start.
- Latency: a sample accepted at edge k appears on out_valid_o/out_data_o after edge k, i.e. in the cycle following acceptance.
- Throughput is 1 sample/clock while out_ready_i=1.
- out_data_o, out_ch_o and out_last_o are held stable while out_valid_o && !out_ready_i.
- Simultaneous input accept and output transfer with skid empty: the main register is overwritten with the new beat and out_valid_o stays 1.
- Full state (main and skid valid): in_ready_o=0 until the first output transfer. in_ready_o rises in the cycle after that transfer.
- Only registered outputs; no input-to-output combinational paths.

## Test plan
- Formats (S_WD=16, L_WD=32, FRAC_SH=4, N_CH=1), in_data_i=0x8001:
  - mode 01 -> 0xFFF80010
  - mode 00 -> 0x00080010
  - mode 10 -> 0x00000010
  - mode 11 -> 0xFFF80010
- Offset-binary edges: mode 10 with 0x0000 -> 0xFFF80000; 0xFFFF -> 0x0007FFF0.
- Channel tagging (N_CH=3): 7 back-to-back beats, frame_start_i on beat 0 only -> out_ch_o 0,1,2,0,1,2,0 and out_last_o on beats 2 and 5. A mode_i change on beat 4 has no effect until beat 6.
- Backpressure: out_ready_i held low for 5 cycles during a stream -> exactly 2 samples are buffered and in_ready_o=0 from the cycle after the second accept. On release, the samples drain in order with no loss or duplication. A random-ready soak of 10k beats matches the scoreboard.
- Frame error: frame_start_i on the beat where ch_q=1 -> frame_err_o=1 from the next cycle and that beat is tagged ch 0. frame_err_o stays 1 until rst_i.
- Async reset with both buffers full -> out_valid_o=0, in_ready_o=1 and frame_err_o=0 before the next clock edge. The first post-reset beat is tagged ch 0.
